// File: rtl/hdmi_overlay_engine_pkg.sv
// Shared definitions for the HDMI overlay engine: sequencing states,
// default widths and a helper that derives porch/sync boundaries.
package hdmi_overlay_engine_pkg;

  localparam int PIX_W_DEF = 24;
  localparam int CNT_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } ovl_state_t;

  // Per-axis timing bundle: total period and the sync pulse window [start, end)
  typedef struct packed {
    logic [15:0] total;
    logic [15:0] sync_start;
    logic [15:0] sync_end;
  } axis_timing_t;

  function automatic axis_timing_t axis_timing(input int act, input int fp,
                                               input int sw, input int bp);
    axis_timing_t t;
    t.total      = 16'(act + fp + sw + bp);
    t.sync_start = 16'(act + fp);
    t.sync_end   = 16'(act + fp + sw);
    return t;
  endfunction

endpackage

// File: rtl/hdmi_overlay_engine_timing_gen.sv
// Raster counters and raw (unpolarised) timing flags. Counters are held at
// zero while run is low so a restart always begins on a frame boundary.
module video_timing_gen
  import hdmi_overlay_engine_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_FRONT  = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BACK   = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FRONT  = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 36,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             run,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             active,
  output logic             hsync_on,
  output logic             vsync_on,
  output logic             frame_boundary
);

  localparam axis_timing_t H_T = axis_timing(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam axis_timing_t V_T = axis_timing(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_T.total - 16'd1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_T.total - 16'd1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_T.sync_start);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_T.sync_end);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_T.sync_start);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_T.sync_end);

  // Pixel and line counters; vertical advances on horizontal wrap
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      h_count <= '0;
      v_count <= '0;
    end else if (!run) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  // Raw timing decode from the current counter state
  always_comb begin
    active         = (h_count < H_ACT) && (v_count < V_ACT);
    hsync_on       = (h_count >= HS_START) && (h_count < HS_END);
    vsync_on       = (v_count >= VS_START) && (v_count < VS_END);
    frame_boundary = (h_count == '0) && (v_count == '0);
  end

endmodule

// File: rtl/hdmi_overlay_engine.sv
// HDMI overlay engine: raster timing plus window blend of a streamed overlay
// over a background colour, with colour-key transparency and SOF locking.
//
// state  | meaning
// IDLE   | timing stopped, counters at 0, syncs inactive, no pixels taken
// HUNT   | window pixels consumed and dropped until SOF lands on first window pixel
// LOCKED | window pixels consumed and displayed (subject to colour key)
module hdmi_overlay_engine
  import hdmi_overlay_engine_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_FRONT  = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BACK   = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FRONT  = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PIX_W    = PIX_W_DEF
) (
  input  logic             clock,
  input  logic             masterReset,
  input  logic             enable,
  input  logic [CNT_W-1:0] winX,
  input  logic [CNT_W-1:0] winY,
  input  logic [CNT_W-1:0] winW,
  input  logic [CNT_W-1:0] winH,
  input  logic [PIX_W-1:0] bgColor,
  input  logic [PIX_W-1:0] keyColor,
  input  logic             keyEnable,
  input  logic [PIX_W-1:0] pixData,
  input  logic             pixSof,
  input  logic             pixValid,
  output logic             pixReady,
  output logic             DE,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic [PIX_W-1:0] data,
  output logic             frameStart,
  output logic             underflow,
  input  logic             clearUnderflow
);

  logic [CNT_W-1:0] h_count, v_count;
  logic             tg_active, tg_hsync, tg_vsync, frame_boundary;
  logic             run, active_run;

  ovl_state_t state, state_nxt, frame_state;

  logic [CNT_W-1:0] sh_x, sh_y, sh_w, sh_h;
  logic [PIX_W-1:0] sh_key;
  logic             sh_key_en;
  logic [CNT_W-1:0] eff_x, eff_y, eff_w, eff_h;
  logic [PIX_W-1:0] eff_key;
  logic             eff_key_en;

  logic [CNT_W:0]   x_end, y_end;
  logic             in_win, first_pix, accept, key_hit, show_pix, uf_set;
  logic [PIX_W-1:0] pix_nxt;

  // Enable is only honoured on the frame boundary; the pixel at (0,0) already
  // belongs to the frame being entered, so it sees the resolved state.
  assign frame_state = !frame_boundary ? state :
                       (!enable ? ST_IDLE : ((state == ST_IDLE) ? ST_HUNT : state));
  assign run         = (frame_state != ST_IDLE);
  assign active_run  = run && tg_active;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .CNT_W    (CNT_W)
  ) u_timing (
    .clock          (clock),
    .rst            (masterReset),
    .run            (run),
    .h_count        (h_count),
    .v_count        (v_count),
    .active         (tg_active),
    .hsync_on       (tg_hsync),
    .vsync_on       (tg_vsync),
    .frame_boundary (frame_boundary)
  );

  // Live settings apply on the boundary pixel itself, shadows for the rest of the frame
  assign eff_x      = frame_boundary ? winX      : sh_x;
  assign eff_y      = frame_boundary ? winY      : sh_y;
  assign eff_w      = frame_boundary ? winW      : sh_w;
  assign eff_h      = frame_boundary ? winH      : sh_h;
  assign eff_key    = frame_boundary ? keyColor  : sh_key;
  assign eff_key_en = frame_boundary ? keyEnable : sh_key_en;

  // Capture window and key settings once per frame
  always_ff @(posedge clock or posedge masterReset) begin
    if (masterReset) begin
      sh_x      <= '0;
      sh_y      <= '0;
      sh_w      <= '0;
      sh_h      <= '0;
      sh_key    <= '0;
      sh_key_en <= 1'b0;
    end else if (frame_boundary) begin
      sh_x      <= winX;
      sh_y      <= winY;
      sh_w      <= winW;
      sh_h      <= winH;
      sh_key    <= keyColor;
      sh_key_en <= keyEnable;
    end
  end

  // Window ends computed one bit wider so x+w never wraps back into the raster
  assign x_end     = {1'b0, eff_x} + {1'b0, eff_w};
  assign y_end     = {1'b0, eff_y} + {1'b0, eff_h};
  assign in_win    = active_run && (eff_w != '0) && (eff_h != '0) &&
                     ({1'b0, h_count} >= {1'b0, eff_x}) && ({1'b0, h_count} < x_end) &&
                     ({1'b0, v_count} >= {1'b0, eff_y}) && ({1'b0, v_count} < y_end);
  assign first_pix = in_win && (h_count == eff_x) && (v_count == eff_y);
  assign accept    = in_win && pixValid;
  assign key_hit   = eff_key_en && (pixData == eff_key);

  // FSM state register
  always_ff @(posedge clock or posedge masterReset) begin
    if (masterReset) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // FSM next state: frame-level resolution, then stream lock tracking
  always_comb begin
    state_nxt = frame_state;
    if (accept) begin
      case (frame_state)
        ST_HUNT:   if (first_pix && pixSof)  state_nxt = ST_LOCKED;
        ST_LOCKED: if (pixSof && !first_pix) state_nxt = ST_HUNT;
        default:   state_nxt = frame_state;
      endcase
    end
  end

  // FSM outputs: stream handshake, underflow request and pixel select
  always_comb begin
    pixReady = in_win;
    uf_set   = in_win && !pixValid;
    show_pix = 1'b0;
    if (accept) begin
      case (frame_state)
        ST_HUNT:   show_pix = first_pix && pixSof;
        ST_LOCKED: show_pix = !(pixSof && !first_pix);
        default:   show_pix = 1'b0;
      endcase
    end
    if (!active_run)                pix_nxt = '0;
    else if (show_pix && !key_hit)  pix_nxt = pixData;
    else                            pix_nxt = bgColor;
  end

  // Registered video outputs, one clock behind the counters
  always_ff @(posedge clock or posedge masterReset) begin
    if (masterReset) begin
      DE         <= 1'b0;
      HSYNC      <= ~HS_POL;
      VSYNC      <= ~VS_POL;
      data       <= '0;
      frameStart <= 1'b0;
    end else begin
      DE         <= active_run;
      HSYNC      <= (run && tg_hsync) ? HS_POL : ~HS_POL;
      VSYNC      <= (run && tg_vsync) ? VS_POL : ~VS_POL;
      data       <= pix_nxt;
      frameStart <= run && frame_boundary;
    end
  end

  // Sticky underflow flag; a clear in the same cycle as a new underflow wins
  always_ff @(posedge clock or posedge masterReset) begin
    if (masterReset)         underflow <= 1'b0;
    else if (clearUnderflow) underflow <= 1'b0;
    else if (uf_set)         underflow <= 1'b1;
  end

endmodule

// File: tb/tb_hdmi_overlay_engine.sv
// Scoreboard bench for hdmi_overlay_engine using a small raster (14x7).
module tb_hdmi_overlay_engine;

  localparam int CW = 12;
  localparam int PW = 24;
  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;
  localparam int M_IDLE = 0, M_HUNT = 1, M_LOCKED = 2;

  logic          clock = 1'b0;
  logic          masterReset, enable, keyEnable, pixSof, pixValid, clearUnderflow;
  logic [CW-1:0] winX, winY, winW, winH;
  logic [PW-1:0] bgColor, keyColor, pixData;
  logic          pixReady, DE, HSYNC, VSYNC, frameStart, underflow;
  logic [PW-1:0] data;

  always #5 clock = ~clock;

  hdmi_overlay_engine #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW), .PIX_W(PW)
  ) dut (
    .clock(clock), .masterReset(masterReset), .enable(enable),
    .winX(winX), .winY(winY), .winW(winW), .winH(winH),
    .bgColor(bgColor), .keyColor(keyColor), .keyEnable(keyEnable),
    .pixData(pixData), .pixSof(pixSof), .pixValid(pixValid), .pixReady(pixReady),
    .DE(DE), .HSYNC(HSYNC), .VSYNC(VSYNC), .data(data), .frameStart(frameStart),
    .underflow(underflow), .clearUnderflow(clearUnderflow)
  );

  typedef struct {
    logic de, hs, vs, fs, uf;
    logic [PW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // reference model state
  int          m_state, m_pos, m_area;
  int          sh_x, sh_y, sh_w, sh_h;
  bit          sh_ke, m_uf, m_ready, m_accept, m_eof;
  logic [PW-1:0] sh_key;

  // overlay source and knobs
  int          s_idx, s_off, s_frame;
  logic [PW-1:0] s_data;
  int          p_valid, p_clear, hs_cnt;
  bit          check_hs, jitter;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] new_src();
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0)      return keyColor;
    else if (r == 1) return keyColor ^ 24'h000100;
    else             return PW'($urandom);
  endfunction

  function automatic int clip_len(input int start, input int len, input int lim);
    int e;
    if (start >= lim) return 0;
    e = start + len;
    if (e > lim) e = lim;
    return e - start;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_pos = 0; m_uf = 0; m_area = 0;
    sh_x = 0; sh_y = 0; sh_w = 0; sh_h = 0; sh_ke = 0; sh_key = '0;
    s_idx = 0; s_data = new_src(); hs_cnt = 0;
  endtask

  // One pixel clock of the behavioural model; pushes the expected registered outputs
  task automatic model_step();
    int x, y;
    bit running, active, inw, first, show;
    logic [PW-1:0] d;
    exp_t e;
    if (m_pos == 0) begin
      if (!enable)                m_state = M_IDLE;
      else if (m_state == M_IDLE) m_state = M_HUNT;
      sh_x = int'(winX); sh_y = int'(winY); sh_w = int'(winW); sh_h = int'(winH);
      sh_key = keyColor; sh_ke = keyEnable;
      m_area = clip_len(sh_x, sh_w, 8) * clip_len(sh_y, sh_h, 4);
      hs_cnt = 0;
    end
    running = (m_state != M_IDLE);
    x = m_pos % HT;
    y = m_pos / HT;
    active = running && x < 8 && y < 4;
    inw = active && sh_w != 0 && sh_h != 0 && x >= sh_x && x < sh_x + sh_w &&
          y >= sh_y && y < sh_y + sh_h;
    first = inw && x == sh_x && y == sh_y;
    m_ready = inw;
    m_accept = inw && pixValid;
    d = active ? bgColor : '0;
    if (m_accept) begin
      show = 0;
      if (m_state == M_HUNT) begin
        if (first && pixSof) begin m_state = M_LOCKED; show = 1; end
      end else if (m_state == M_LOCKED) begin
        if (pixSof && !first) m_state = M_HUNT;
        else show = 1;
      end
      if (show && !(sh_ke && pixData == sh_key)) d = pixData;
    end
    if (clearUnderflow)        m_uf = 0;
    else if (inw && !pixValid) m_uf = 1;
    e.de = active;
    e.hs = running && x >= 10 && x < 12;
    e.vs = running && y == 5;
    e.fs = running && m_pos == 0;
    e.uf = m_uf;
    e.data = d;
    exp_q.push_back(e);
    m_eof = running && m_pos == FT - 1;
    m_pos = running ? (m_pos + 1) % FT : 0;
  endtask

  // Drive one cycle at the falling edge; returns just after the next rising edge
  task automatic step();
    @(negedge clock);
    if (jitter && $urandom_range(0, 19) == 0) begin
      winX = CW'($urandom_range(0, 9));
      winY = CW'($urandom_range(0, 4));
      winW = CW'($urandom_range(0, 6));
      winH = CW'($urandom_range(0, 3));
      keyEnable = 1'($urandom_range(0, 1));
      bgColor = PW'($urandom);
    end
    pixValid = ($urandom_range(0, 99) < p_valid);
    pixData = s_data;
    pixSof = ((s_idx + s_off) % s_frame == 0);
    clearUnderflow = ($urandom_range(0, 99) < p_clear);
    model_step();
    #1;
    check("pixReady", 32'(pixReady), 32'(m_ready));
    if (pixValid && pixReady) hs_cnt++;
    if (m_accept) begin s_idx++; s_data = new_src(); end
    if (check_hs && m_eof) check("handshakes_per_frame", 32'(hs_cnt), 32'(m_area));
    @(posedge clock);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_DE"}, 32'(DE), 32'd0);
    check({tag, "_HSYNC"}, 32'(HSYNC), 32'd0);
    check({tag, "_VSYNC"}, 32'(VSYNC), 32'd0);
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_frameStart"}, 32'(frameStart), 32'd0);
    check({tag, "_underflow"}, 32'(underflow), 32'd0);
    check({tag, "_pixReady"}, 32'(pixReady), 32'd0);
  endtask

  // Monitor: compares registered outputs against the queued expectations
  always @(posedge clock) begin
    #1;
    if (mon_en && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("DE", 32'(DE), 32'(mon_e.de));
      check("HSYNC", 32'(HSYNC), 32'(mon_e.hs));
      check("VSYNC", 32'(VSYNC), 32'(mon_e.vs));
      check("frameStart", 32'(frameStart), 32'(mon_e.fs));
      check("underflow", 32'(underflow), 32'(mon_e.uf));
      check("data", 32'(data), 32'(mon_e.data));
    end
  end

  initial begin
    masterReset = 1'b1; enable = 1'b0;
    winX = '0; winY = '0; winW = '0; winH = '0;
    bgColor = 24'h123456; keyColor = 24'h00FF00; keyEnable = 1'b0;
    pixData = '0; pixSof = 1'b0; pixValid = 1'b0; clearUnderflow = 1'b0;
    p_valid = 100; p_clear = 0; check_hs = 0; jitter = 0; s_frame = 6; s_off = 0;
    #12;
    check_reset_outputs("reset");
    @(posedge clock); #2;
    masterReset = 1'b0;
    model_reset();
    mon_en = 1'b1;

    run(3);                                   // stays idle with enable low
    enable = 1'b1;
    winX = 2; winY = 1; winW = 3; winH = 2;
    check_hs = 1;
    run(3 * FT);                              // basic timing and window
    keyEnable = 1'b1;
    run(3 * FT);                              // colour key
    check_hs = 0; p_valid = 80; p_clear = 10;
    run(4 * FT);                              // underflow and clear
    p_valid = 100; p_clear = 0; check_hs = 1;
    s_idx = 0; s_off = 1;
    run(FT);                                  // SOF missing at first window pixel
    s_idx = 0; s_off = 0;
    run(2 * FT);                              // relock
    winX = 7; winW = 5;
    run(2 * FT);                              // clipped window
    winW = 0;
    run(FT);                                  // window off
    check_hs = 0; jitter = 1; p_valid = 90; p_clear = 5;
    run(10 * FT);                             // randomized
    jitter = 0; p_valid = 100; p_clear = 0;
    winX = 1; winY = 0; winW = 4; winH = 3;
    run(40);
    enable = 1'b0;
    run(70);                                  // frame finishes, then idle
    enable = 1'b1;
    run(FT + 18);                             // stop mid-line at an active pixel

    mon_en = 1'b0;
    masterReset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    @(posedge clock); #2;
    masterReset = 1'b0;
    model_reset();
    mon_en = 1'b1;
    run(FT + 5);                              // restart from IDLE

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
